lane_permute_undo: RTL
======================

# lane_permute_undo

Four-lane register permuter with a reversible history. Each accepted command updates all lanes at one clock edge, using the old lane values for every lane. Swap and rotate commands record their inverse on a bounded history stack, so the block can undo one step or unwind the whole stack. It is the synthesizable device-under-test counterpart to the codebase's NBA swap/chain checks, and it exercises simultaneous multi-register updates in the hardware path.

## Interface
Parameters:
- W, 8, lane width in bits
- DEPTH, 4, history entries; power of two, 2 to 16

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  3  0 NOP, 1 LOAD, 2 SWAP, 3 ROT, 4 UNDO, 5 UNDO_ALL, 6–7 illegal
- cmd_sel  in  4  SWAP: {a[3:2], b[1:0]} lane indices; ROT: k = cmd_sel[1:0]; otherwise ignored
- cmd_data  in  4*W  LOAD value; lane i occupies bits [i*W +: W]
- lanes_q  out  4*W  current lane contents, registered
- hist_count  out  $clog2(DEPTH)+1  number of valid history entries
- err  out  1  one-cycle pulse on an illegal op or an UNDO with empty history

## Operation
- A command is accepted on a rising edge where cmd_valid && cmd_ready. Every lane update on that edge is computed from the pre-edge lane values; there is no sequential or partial visibility.
- NOP: no state change.
- LOAD: lanes <= cmd_data; history cleared (hist_count <= 0).
- SWAP(a,b): lane[a] <= lane[b], lane[b] <= lane[a]. If a == b, lanes are unchanged but the entry is still pushed.
- ROT(k): lane[i] <= lane[(i+k) mod 4] for all i. k = 0 is the identity and is still pushed.
- Push rule for SWAP and ROT:
  - The entry pushed is {kind, sel}.
  - When the stack is full, the push overwrites the oldest entry; hist_count stays at DEPTH.
- UNDO: pops the newest entry and applies its inverse.
  - SWAP is its own inverse.
  - The inverse of ROT(k) is ROT((4-k) mod 4).
  - With an empty stack: err pulses and lanes are unchanged.
- UNDO_ALL:
  - Empty stack: no-op, no err.
  - Otherwise the block enters UNWIND. It pops and applies one inverse per cycle until hist_count reaches 0, then returns to IDLE.
- Illegal op (6 or 7): err pulses, no state change.
- FSM:
  - IDLE: cmd_ready = 1.
  - IDLE to UNWIND on an accepted UNDO_ALL with hist_count > 0.
  - UNWIND: cmd_ready = 0; cmd inputs are ignored.
  - UNWIND to IDLE on the edge that performs the last pop.

## Timing
- Reset values:
  - lanes_q = 0
  - hist_count = 0
  - err = 0
  - state = IDLE
  - cmd_ready = 1 from the first cycle after reset
- Reset asserted mid-UNWIND aborts the unwind immediately; all reset values apply.
- Latency:
  - lanes_q reflects an accepted command on the cycle after the accepting edge.
  - err is asserted for exactly the cycle after the offending acceptance.
- UNWIND with N entries:
  - The first pop occurs on the edge after acceptance.
  - cmd_ready is low for exactly N cycles.
  - lanes_q is fully restored and hist_count = 0 when cmd_ready rises.
- cmd_ready is a registered function of state only; it has no combinational path from cmd_valid.
- Overwrite wrap-around: after DEPTH+m pushes with no pops, DEPTH undos restore the state after the first m commands, and the next UNDO raises err.

## Structure
- Package lane_permute_pkg:
  - op enum (NOP..UNDO_ALL)
  - hist_entry_t struct {kind: 1 bit, sel: 4 bits}
  - function inv_entry() returning the inverse entry
  - function apply_perm() computing next lanes from current lanes plus an entry
- Sub-module lane_hist_stack:
  - DEPTH x hist_entry_t circular LIFO
  - Ports: push, pop, clear, push_data, top, count
  - Push when full overwrites the oldest entry.
  - Simultaneous push and pop never occurs.
- The top level holds the lane registers, the FSM and the err register.

## Test plan
- Setup for scenarios 1–5: LOAD lanes (0..3) = 10, 20, 30, 40.
1. SWAP(0,1) -> lanes 20, 10, 30, 40; hist_count = 1.
2. From 1, ROT(2) -> lanes 30, 40, 20, 10 (all four updated at the same edge); UNDO -> 20, 10, 30, 40; UNDO -> 10, 20, 30, 40; UNDO -> err pulse, lanes unchanged.
3. Four pushes (SWAP(0,1), ROT(1), SWAP(2,3), ROT(3)) then UNDO_ALL -> cmd_ready low for exactly 4 cycles; lanes = 10, 20, 30, 40; hist_count = 0.
4. DEPTH+2 = 6 ROT(1) pushes -> hist_count = 4. UNDO four times -> lanes equal the state after the 2nd ROT (30, 40, 10, 20). Fifth UNDO -> err pulse.
5. Reset asserted on the 2nd UNWIND cycle -> the next cycle shows lanes 0, hist_count 0, cmd_ready 1; a following LOAD is accepted normally.
6. cmd_op = 7 and UNDO_ALL on an empty stack -> err pulse for the first only; lanes and cmd_ready unchanged in both cases.

Source files
------------

// File: rtl/lane_permute_pkg.sv
// lane_permute_pkg
// Shared types and helpers for the four-lane permuter with undo history.
//   op_e          command opcodes carried on cmd_op (6 and 7 are illegal)
//   hist_entry_t  one history record: kind (swap or rotate) plus the raw 4-bit select
//   perm_map_t    for each destination lane, the index of the lane it reads from
//   inv_entry()   the entry that undoes a given entry
//   apply_perm()  the source-lane map that an entry applies to the lanes
package lane_permute_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_SWAP     = 3'd2,
        OP_ROT      = 3'd3,
        OP_UNDO     = 3'd4,
        OP_UNDO_ALL = 3'd5
    } op_e;

    localparam logic KIND_SWAP = 1'b0;
    localparam logic KIND_ROT  = 1'b1;

    typedef logic [1:0] lane_idx_t;
    typedef lane_idx_t [3:0] perm_map_t;

    typedef struct packed {
        logic       kind;
        logic [3:0] sel;
    } hist_entry_t;

    // A swap undoes itself. A rotate by k is undone by a rotate by -k mod 4,
    // which is plain 2-bit negation. The swap index bits are left untouched.
    function automatic hist_entry_t inv_entry(input hist_entry_t e);
        hist_entry_t r;
        r = e;
        if (e.kind == KIND_ROT) begin
            r.sel[1:0] = 2'd0 - e.sel[1:0];
        end
        return r;
    endfunction

    // The map is built from the entry alone, so the top level can move whole
    // lanes of any width with one mux per lane. All lanes read pre-edge values.
    function automatic perm_map_t apply_perm(input hist_entry_t e);
        perm_map_t m;
        lane_idx_t a;
        lane_idx_t b;
        lane_idx_t li;
        a = e.sel[3:2];
        b = e.sel[1:0];
        for (int i = 0; i < 4; i++) begin
            li = lane_idx_t'(i);
            if (e.kind == KIND_ROT) begin
                m[i] = li + e.sel[1:0];
            end else if (li == a) begin
                m[i] = b;
            end else if (li == b) begin
                m[i] = a;
            end else begin
                m[i] = li;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_hist_stack.sv
// lane_hist_stack
// Bounded circular LIFO of history entries. When the stack is full, a push
// overwrites the oldest entry and the count stays at DEPTH.
//   clk, rst    clock and synchronous active-high reset
//   push        store push_data as the newest entry
//   pop         discard the newest entry (ignored when empty)
//   clear       drop all entries; it takes priority over push and pop
//   push_data   entry to store
//   top         newest entry; only meaningful while count > 0
//   count       number of valid entries, 0..DEPTH
// push and pop are never asserted together by the owner.
module lane_hist_stack
    import lane_permute_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  hist_entry_t              push_data,
    output hist_entry_t              top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    hist_entry_t     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;

    // wr_ptr is the next free slot. When the stack is full, that slot holds
    // the oldest entry, so pointer wrap-around is the overwrite.
    assign top = mem[wr_ptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && count != '0) begin
            wr_ptr <= wr_ptr - PW'(1);
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/lane_permute_undo.sv
// lane_permute_undo
// Four-lane register permuter with a reversible history. Each accepted
// command updates every lane at one edge from the pre-edge lane values.
// SWAP and ROT push their entry. UNDO pops one entry and applies its
// inverse. UNDO_ALL unwinds the whole stack, one entry per cycle.
//   clk, rst     clock and synchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    high in IDLE, low while unwinding
//   cmd_op       0 NOP, 1 LOAD, 2 SWAP, 3 ROT, 4 UNDO, 5 UNDO_ALL, 6-7 illegal
//   cmd_sel      SWAP {a,b} lane indices; ROT k in [1:0]
//   cmd_data     LOAD value; lane i is cmd_data[i*W +: W]
//   lanes_q      registered lane contents
//   hist_count   number of valid history entries
//   err          one-cycle pulse for an illegal op or an UNDO on an empty stack
module lane_permute_undo
    import lane_permute_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_sel,
    input  logic [4*W-1:0]           cmd_data,
    output logic [4*W-1:0]           lanes_q,
    output logic [$clog2(DEPTH):0]   hist_count,
    output logic                     err
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE,
        UNWIND
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [3:0][W-1:0]   lanes;
    logic [3:0][W-1:0]   lanes_n;
    logic [3:0][W-1:0]   permuted;
    logic                err_n;
    logic                push;
    logic                pop;
    logic                clear;
    logic                accept;
    op_e                 op;
    hist_entry_t         cmd_entry;
    hist_entry_t         top_entry;
    hist_entry_t         perm_entry;
    perm_map_t           src_map;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign lanes_q   = lanes;
    assign cmd_entry = '{kind: (op == OP_ROT) ? KIND_ROT : KIND_SWAP, sel: cmd_sel};

    // One shared permutation network. A fresh SWAP/ROT in IDLE uses the
    // command. Everything else that moves lanes (UNDO, the unwind pops) uses
    // the inverse of the newest history entry.
    assign perm_entry = (state == IDLE && (op == OP_SWAP || op == OP_ROT))
                        ? cmd_entry : inv_entry(top_entry);
    assign src_map    = apply_perm(perm_entry);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            permuted[i] = lanes[src_map[i]];
        end
    end

    lane_hist_stack #(
        .DEPTH (DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (cmd_entry),
        .top       (top_entry),
        .count     (hist_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lanes <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            lanes <= lanes_n;
            err   <= err_n;
        end
    end

    // While unwinding, the command inputs are ignored. The last pop happens
    // on the same edge that returns to IDLE, so cmd_ready rises together
    // with hist_count reaching zero.
    always_comb begin
        state_n = state;
        lanes_n = lanes;
        err_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_NOP: begin
                        end
                        OP_LOAD: begin
                            lanes_n = cmd_data;
                            clear   = 1'b1;
                        end
                        OP_SWAP, OP_ROT: begin
                            lanes_n = permuted;
                            push    = 1'b1;
                        end
                        OP_UNDO: begin
                            if (hist_count == '0) begin
                                err_n = 1'b1;
                            end else begin
                                lanes_n = permuted;
                                pop     = 1'b1;
                            end
                        end
                        OP_UNDO_ALL: begin
                            if (hist_count != '0) begin
                                state_n = UNWIND;
                            end
                        end
                        default: begin
                            err_n = 1'b1;
                        end
                    endcase
                end
            end
            UNWIND: begin
                if (hist_count == '0) begin
                    state_n = IDLE;
                end else begin
                    lanes_n = permuted;
                    pop     = 1'b1;
                    if (hist_count == CW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
